// File: rtl/i2c_slave_rw.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// i2c_slave_rw
//   I2C target endpoint for the SPI/I2C bridge. SCL and SDA are oversampled on
//   rd_clk, which must run at least 16x the SCL frequency. Master-write bytes
//   are pushed into an RX FIFO. Master-read bytes are popped from a TX FIFO,
//   one pop per transmitted byte. Repeated START and STOP are honoured from
//   every state.
//
// Ports
//   rd_clk          system clock
//   rd_rst_n        asynchronous active-low reset
//   i_scl           I2C clock (asynchronous)
//   i_sda_in        I2C data pad input (asynchronous)
//   o_sda_oe        1 = pull SDA low, 0 = release (open drain)
//   i_tx_data       TX FIFO read data, valid TX_RD_LATENCY cycles after pop
//   i_tx_empty      TX FIFO empty
//   o_tx_rd_en      TX FIFO pop strobe (one cycle)
//   o_rx_data       received byte, qualified by o_rx_valid
//   o_rx_valid      RX FIFO push strobe (one cycle)
//   i_rx_full       RX FIFO full; a byte arriving while full is NACKed
//   o_busy          high from an addressed START until the following STOP
//   o_nack_seen     pulse: master NACKed a read byte
//   o_rx_overflow   pulse: write byte NACKed because the RX FIFO was full
//   o_tx_underrun   pulse: UNDERRUN_BYTE substituted for an empty TX FIFO
// -----------------------------------------------------------------------------
module i2c_slave_rw #(
  parameter logic [6:0] MY_ADDR       = 7'h25,
  parameter int         SYNC_STAGES   = 2,
  parameter int         TX_RD_LATENCY = 1,
  parameter logic [7:0] UNDERRUN_BYTE = 8'hFF
) (
  input  logic       rd_clk,
  input  logic       rd_rst_n,
  input  logic       i_scl,
  input  logic       i_sda_in,
  output logic       o_sda_oe,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_empty,
  output logic       o_tx_rd_en,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic       i_rx_full,
  output logic       o_busy,
  output logic       o_nack_seen,
  output logic       o_rx_overflow,
  output logic       o_tx_underrun
);

  // Out-of-range parameters are clamped to the supported range.
  localparam int SS  = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int LAT = (TX_RD_LATENCY < 1) ? 1 : ((TX_RD_LATENCY > 2) ? 2 : TX_RD_LATENCY);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADDR     = 3'd1;
  localparam logic [2:0] S_ADDR_ACK = 3'd2;
  localparam logic [2:0] S_WR_DATA  = 3'd3;
  localparam logic [2:0] S_WR_ACK   = 3'd4;
  localparam logic [2:0] S_RD_DATA  = 3'd5;
  localparam logic [2:0] S_RD_ACK   = 3'd6;

  logic [SS-1:0] r_scl_sync;
  logic [SS-1:0] r_sda_sync;
  logic          r_scl_d;
  logic          r_sda_d;

  logic [2:0]    r_state;
  logic [3:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_rw;
  logic          r_nack;
  logic [1:0]    r_cap_pipe;

  logic          r_sda_oe;
  logic          r_tx_rd_en;
  logic [7:0]    r_rx_data;
  logic          r_rx_valid;
  logic          r_busy;
  logic          r_nack_seen;
  logic          r_rx_overflow;
  logic          r_tx_underrun;

  logic          w_scl;
  logic          w_sda;
  logic          w_scl_rise;
  logic          w_scl_fall;
  logic          w_start;
  logic          w_stop;
  logic          w_fetch;
  logic          w_capture;

  // Synchronisers idle high (bus released) plus one edge-detect flop each.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      r_scl_sync <= {SS{1'b1}};
      r_sda_sync <= {SS{1'b1}};
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SS-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SS-2:0], i_sda_in};
      r_scl_d    <= r_scl_sync[SS-1];
      r_sda_d    <= r_sda_sync[SS-1];
    end
  end

  assign w_scl      = r_scl_sync[SS-1];
  assign w_sda      = r_sda_sync[SS-1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  // SCL must be high in both samples, so START/STOP can never coincide with
  // an SCL edge and the bus conditions always win over data actions.
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

  // A byte is fetched on the ACK-bit rising edge: after the address of a read,
  // and after every master ACK of a read byte. A master NACK fetches nothing.
  assign w_fetch    = w_scl_rise &
                      (((r_state == S_ADDR_ACK) & r_rw) |
                       ((r_state == S_RD_ACK) & ~w_sda));
  assign w_capture  = r_cap_pipe[LAT-1];

  // Protocol FSM, shift register, SDA driver and all strobe outputs.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      r_state       <= S_IDLE;
      r_bit_cnt     <= 4'd0;
      r_shift       <= 8'd0;
      r_rw          <= 1'b0;
      r_nack        <= 1'b0;
      r_cap_pipe    <= 2'b00;
      r_sda_oe      <= 1'b0;
      r_tx_rd_en    <= 1'b0;
      r_rx_data     <= 8'd0;
      r_rx_valid    <= 1'b0;
      r_busy        <= 1'b0;
      r_nack_seen   <= 1'b0;
      r_rx_overflow <= 1'b0;
      r_tx_underrun <= 1'b0;
    end else begin
      r_tx_rd_en    <= 1'b0;
      r_rx_valid    <= 1'b0;
      r_nack_seen   <= 1'b0;
      r_rx_overflow <= 1'b0;
      r_tx_underrun <= 1'b0;
      // Delay line from the pop strobe to the cycle where tx data is valid.
      r_cap_pipe    <= {r_cap_pipe[0], r_tx_rd_en};

      if (w_start) begin
        r_state    <= S_ADDR;
        r_bit_cnt  <= 4'd0;
        r_sda_oe   <= 1'b0;
        r_nack     <= 1'b0;
        r_cap_pipe <= 2'b00;
      end else if (w_stop) begin
        r_state    <= S_IDLE;
        r_bit_cnt  <= 4'd0;
        r_sda_oe   <= 1'b0;
        r_busy     <= 1'b0;
        r_nack     <= 1'b0;
        r_cap_pipe <= 2'b00;
      end else begin
        if (w_capture) begin
          r_shift <= i_tx_data;
        end

        if (w_fetch) begin
          if (!i_tx_empty) begin
            r_tx_rd_en <= 1'b1;
          end else begin
            r_shift       <= UNDERRUN_BYTE;
            r_tx_underrun <= 1'b1;
          end
        end

        case (r_state)
          S_IDLE: begin
            r_sda_oe <= 1'b0;
          end

          S_ADDR: begin
            if (w_scl_rise) begin
              r_shift <= {r_shift[6:0], w_sda};
              if (r_bit_cnt != 4'd8) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end else if (w_scl_fall && (r_bit_cnt == 4'd8)) begin
              r_bit_cnt <= 4'd0;
              if (r_shift[7:1] == MY_ADDR) begin
                r_state  <= S_ADDR_ACK;
                r_rw     <= r_shift[0];
                r_sda_oe <= 1'b1;
                r_busy   <= 1'b1;
              end else begin
                // Not for us: stay off the bus until the next START.
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            end
          end

          S_ADDR_ACK: begin
            if (w_scl_fall) begin
              r_bit_cnt <= 4'd0;
              if (r_rw) begin
                r_state  <= S_RD_DATA;
                r_sda_oe <= ~r_shift[7];
              end else begin
                r_state  <= S_WR_DATA;
                r_sda_oe <= 1'b0;
              end
            end
          end

          S_WR_DATA: begin
            if (w_scl_rise) begin
              r_shift <= {r_shift[6:0], w_sda};
              if (r_bit_cnt != 4'd8) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end else if (w_scl_fall && (r_bit_cnt == 4'd8)) begin
              r_bit_cnt <= 4'd0;
              r_state   <= S_WR_ACK;
              if (!i_rx_full) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
                r_sda_oe   <= 1'b1;
              end else begin
                r_sda_oe      <= 1'b0;
                r_rx_overflow <= 1'b1;
              end
            end
          end

          S_WR_ACK: begin
            if (w_scl_fall) begin
              r_sda_oe <= 1'b0;
              r_state  <= S_WR_DATA;
            end
          end

          S_RD_DATA: begin
            if (w_scl_fall) begin
              if (r_bit_cnt == 4'd7) begin
                // Last bit done: release so the master can ACK/NACK.
                r_bit_cnt <= 4'd0;
                r_sda_oe  <= 1'b0;
                r_state   <= S_RD_ACK;
              end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
                r_shift   <= {r_shift[6:0], 1'b0};
                r_sda_oe  <= ~r_shift[6];
              end
            end
          end

          S_RD_ACK: begin
            if (w_scl_rise) begin
              r_nack      <= w_sda;
              r_nack_seen <= w_sda;
            end else if (w_scl_fall) begin
              r_bit_cnt <= 4'd0;
              if (r_nack) begin
                // Transfer finished by the master; busy holds until STOP.
                r_state  <= S_IDLE;
                r_sda_oe <= 1'b0;
              end else begin
                r_state  <= S_RD_DATA;
                r_sda_oe <= ~r_shift[7];
              end
            end
          end

          default: begin
            r_state   <= S_IDLE;
            r_bit_cnt <= 4'd0;
            r_sda_oe  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_sda_oe      = r_sda_oe;
  assign o_tx_rd_en    = r_tx_rd_en;
  assign o_rx_data     = r_rx_data;
  assign o_rx_valid    = r_rx_valid;
  assign o_busy        = r_busy;
  assign o_nack_seen   = r_nack_seen;
  assign o_rx_overflow = r_rx_overflow;
  assign o_tx_underrun = r_tx_underrun;

endmodule

// File: tb/tb_i2c_slave_rw.sv
`timescale 1ns/1ps
// Testbench for i2c_slave_rw: bit-level I2C master, TX FIFO model and a
// transaction-level reference of what the target must do.
module tb_i2c_slave_rw;

  localparam int         Q       = 8;        // rd_clk cycles per quarter SCL period
  localparam logic [6:0] MY_ADDR = 7'h25;

  logic       rd_clk   = 1'b0;
  logic       rd_rst_n = 1'b0;
  logic       m_scl    = 1'b1;
  logic       m_sda    = 1'b1;
  logic       rx_full  = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_empty;
  logic       sda_oe, tx_rd_en, rx_valid, busy, nack_seen, rx_overflow, tx_underrun;
  logic [7:0] rx_data;
  wire        sda_line;

  int n_checks = 0;
  int n_fail   = 0;

  assign sda_line = m_sda & ~sda_oe;

  always #5 rd_clk = ~rd_clk;

  i2c_slave_rw #(
    .MY_ADDR(MY_ADDR), .SYNC_STAGES(2), .TX_RD_LATENCY(1), .UNDERRUN_BYTE(8'hFF)
  ) dut (
    .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .i_scl(m_scl), .i_sda_in(sda_line),
    .o_sda_oe(sda_oe), .i_tx_data(tx_data), .i_tx_empty(tx_empty),
    .o_tx_rd_en(tx_rd_en), .o_rx_data(rx_data), .o_rx_valid(rx_valid),
    .i_rx_full(rx_full), .o_busy(busy), .o_nack_seen(nack_seen),
    .o_rx_overflow(rx_overflow), .o_tx_underrun(tx_underrun)
  );

  // TX FIFO: data appears one cycle after the pop strobe.
  logic [7:0] tx_mem [0:255];
  int tx_wp = 0;
  int tx_rp = 0;
  assign tx_empty = (tx_rp == tx_wp);
  always @(posedge rd_clk) begin
    if (tx_rd_en) begin
      tx_data <= tx_mem[tx_rp[7:0]];
      tx_rp   <= tx_rp + 1;
    end
  end

  // Event counters and RX capture, sampled on the falling edge.
  int c_rd_en = 0, c_rx_valid = 0, c_nack = 0, c_ovf = 0, c_unr = 0, c_oe = 0, c_busy = 0;
  logic [7:0] rx_got [$];
  always @(negedge rd_clk) begin
    if (tx_rd_en)    c_rd_en    <= c_rd_en + 1;
    if (rx_valid)    c_rx_valid <= c_rx_valid + 1;
    if (nack_seen)   c_nack     <= c_nack + 1;
    if (rx_overflow) c_ovf      <= c_ovf + 1;
    if (tx_underrun) c_unr      <= c_unr + 1;
    if (sda_oe)      c_oe       <= c_oe + 1;
    if (busy)        c_busy     <= c_busy + 1;
    if (rx_valid)    rx_got.push_back(rx_data);
  end

  // Reference: bytes the FIFO will hand out, and bytes the target must push.
  logic [7:0] mdl_fifo [$];
  logic [7:0] rx_exp   [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(posedge rd_clk);
    #1;
  endtask

  task automatic fifo_push(input logic [7:0] d);
    tx_mem[tx_wp[7:0]] = d;
    tx_wp++;
    mdl_fifo.push_back(d);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b1; wait_q();
    wait_q();
  endtask

  task automatic wr_bit(input logic b);
    m_sda = b; wait_q();
    m_scl = 1'b1; wait_q(); wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic rd_bit(output logic b);
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    b = sda_line; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack_n);
    for (int i = 7; i >= 0; i--) wr_bit(d[i]);
    rd_bit(ack_n);
  endtask

  task automatic rd_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rd_bit(b);
      d[i] = b;
    end
    wr_bit(nack);
  endtask

  task automatic cmp_rx(input string tag);
    chk({tag, ":rx_count"}, rx_got.size(), rx_exp.size());
    while (rx_exp.size() > 0 && rx_got.size() > 0)
      chk({tag, ":rx_byte"}, rx_got.pop_front(), rx_exp.pop_front());
    rx_exp.delete();
    rx_got.delete();
  endtask

  // Full write transaction; full_pat[i] is rx_full while byte i is sent.
  task automatic xfer_write(input logic [6:0] addr, input int n, input logic [7:0] data [4],
                            input logic [3:0] full_pat, input string tag);
    int   b_val = c_rx_valid, b_ovf = c_ovf, b_oe = c_oe, b_busy = c_busy;
    int   e_push = 0, e_ovf = 0;
    logic ack_n;
    logic hit = (addr == MY_ADDR);
    bus_start();
    wr_byte({addr, 1'b0}, ack_n);
    chk({tag, ":addr_ack"}, ack_n, hit ? 1'b0 : 1'b1);
    chk({tag, ":busy_mid"}, busy, hit);
    for (int i = 0; i < n; i++) begin
      rx_full = full_pat[i];
      wr_byte(data[i], ack_n);
      if (hit && !full_pat[i]) begin
        rx_exp.push_back(data[i]);
        e_push++;
      end
      if (hit && full_pat[i]) e_ovf++;
      chk({tag, ":data_ack"}, ack_n, (hit && !full_pat[i]) ? 1'b0 : 1'b1);
    end
    rx_full = 1'b0;
    bus_stop();
    chk({tag, ":rx_valid_cnt"}, c_rx_valid - b_val, e_push);
    chk({tag, ":overflow_cnt"}, c_ovf - b_ovf, e_ovf);
    chk({tag, ":busy_end"}, busy, 1'b0);
    if (!hit) begin
      chk({tag, ":oe_never"}, c_oe - b_oe, 0);
      chk({tag, ":busy_never"}, c_busy - b_busy, 0);
    end
    cmp_rx(tag);
  endtask

  // Addressed read of n bytes; master ACKs all but the last.
  task automatic xfer_read(input int n, input string tag);
    int         b_rd = c_rd_en, b_unr = c_unr, b_nack = c_nack;
    int         e_pop = 0, e_unr = 0;
    logic       ack_n;
    logic [7:0] d, e;
    bus_start();
    wr_byte({MY_ADDR, 1'b1}, ack_n);
    chk({tag, ":addr_ack"}, ack_n, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (mdl_fifo.size() > 0) begin
        e = mdl_fifo.pop_front();
        e_pop++;
      end else begin
        e = 8'hFF;
        e_unr++;
      end
      rd_byte(d, (i == n - 1));
      chk({tag, ":rd_byte"}, d, e);
    end
    bus_stop();
    chk({tag, ":rd_en_cnt"}, c_rd_en - b_rd, e_pop);
    chk({tag, ":underrun_cnt"}, c_unr - b_unr, e_unr);
    chk({tag, ":nack_cnt"}, c_nack - b_nack, 1);
    chk({tag, ":busy_end"}, busy, 1'b0);
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] wd [4];
    logic [7:0] d, e;
    logic       ack_n, b;
    logic [2:0] bits;
    int         n, b_rd, b_unr;

    repeat (3) @(posedge rd_clk);
    #1;
    chk("reset_outputs", {sda_oe, tx_rd_en, rx_valid, busy, nack_seen, rx_overflow,
                          tx_underrun, rx_data}, 15'd0);
    rd_rst_n = 1'b1;
    wait_q();

    wd = '{8'h3C, 8'hA5, 8'h00, 8'h00};
    xfer_write(MY_ADDR, 2, wd, 4'b0000, "write");

    fifo_push(8'h11); fifo_push(8'h22); fifo_push(8'h33);
    xfer_read(3, "read");

    wd = '{8'h5A, 8'h77, 8'h00, 8'h00};
    xfer_write(7'h26, 2, wd, 4'b0000, "wrong_addr");

    wd = '{8'h3C, 8'hA5, 8'h5A, 8'h00};
    xfer_write(MY_ADDR, 3, wd, 4'b0010, "rx_full");

    xfer_read(1, "underrun");

    // Write one byte, repeated START, then a one-byte read.
    fifo_push(8'(($urandom & 32'hFF)));
    b_rd = c_rd_en;
    bus_start();
    wr_byte({MY_ADDR, 1'b0}, ack_n);
    chk("rs:addr_w_ack", ack_n, 1'b0);
    wr_byte(8'h01, ack_n);
    chk("rs:data_ack", ack_n, 1'b0);
    rx_exp.push_back(8'h01);
    bus_start();
    wr_byte({MY_ADDR, 1'b1}, ack_n);
    chk("rs:addr_r_ack", ack_n, 1'b0);
    chk("rs:busy", busy, 1'b1);
    e = mdl_fifo.pop_front();
    rd_byte(d, 1'b1);
    chk("rs:rd_byte", d, e);
    bus_stop();
    chk("rs:rd_en_cnt", c_rd_en - b_rd, 1);
    cmp_rx("rs");

    // Reset in the middle of a read byte whose bits are all zero.
    fifo_push(8'h00);
    bus_start();
    wr_byte({MY_ADDR, 1'b1}, ack_n);
    chk("rst:addr_ack", ack_n, 1'b0);
    void'(mdl_fifo.pop_front());
    for (int i = 0; i < 3; i++) begin
      rd_bit(b);
      bits[i] = b;
    end
    chk("rst:bits_low", bits, 3'b000);
    chk("rst:oe_before", sda_oe, 1'b1);
    #2 rd_rst_n = 1'b0;
    #1;
    chk("rst:oe_released", sda_oe, 1'b0);
    chk("rst:outputs", {tx_rd_en, rx_valid, busy, nack_seen, rx_overflow, tx_underrun}, 6'd0);
    repeat (4) @(posedge rd_clk);
    #1 rd_rst_n = 1'b1;
    m_sda = 1'b1;
    m_scl = 1'b1;
    wait_q(); wait_q();
    wd = '{8'(($urandom & 32'hFF)), 8'(($urandom & 32'hFF)), 8'h00, 8'h00};
    xfer_write(MY_ADDR, 2, wd, 4'b0000, "after_rst_w");
    fifo_push(8'(($urandom & 32'hFF)));
    xfer_read(1, "after_rst_r");

    // Randomised transactions against the reference.
    for (int it = 0; it < 10; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        logic [6:0] a;
        logic [3:0] fp;
        a = ($urandom_range(0, 3) == 0) ? 7'(($urandom_range(0, 127))) : MY_ADDR;
        n = $urandom_range(1, 4);
        for (int k = 0; k < 4; k++) begin
          wd[k] = 8'(($urandom & 32'hFF));
          fp[k] = ($urandom_range(0, 3) == 0);
        end
        xfer_write(a, n, wd, fp, "rand_w");
      end else begin
        n = $urandom_range(0, 3);
        for (int k = 0; k < n; k++) fifo_push(8'(($urandom & 32'hFF)));
        b_unr = c_unr;
        xfer_read($urandom_range(1, 3), "rand_r");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
